// File: rtl/sc_dec8_ctrl.sv
// Sequential SC decoder controller for N=8 polar codes, sharing one external f/g unit (one op per cycle, 24 ops).
// Optional feature macro SC_FROZEN_SKIP_EN: skip leaf ops that only produce a frozen bit.
module sc_dec8_ctrl #(
  parameter int LLR_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8*LLR_W-1:0] llr_in,
  input  logic [7:0]         frozen,
  output logic               busy,
  output logic               done,
  output logic [7:0]         u_hat,
  output logic [LLR_W-1:0]   fg_a,
  output logic [LLR_W-1:0]   fg_b,
  output logic               fg_f_flag,
  output logic               fg_s,
  input  logic [LLR_W-1:0]   fg_dout
);

  localparam logic [4:0] N_OPS = 5'd24;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d, nxt;
  logic [LLR_W-1:0] ch_q [8];
  logic [LLR_W-1:0] l4_q [4];
  logic [LLR_W-1:0] l2_q [2];
  logic [7:0]       u_q, frz_q;
  logic             accept;
  logic [3:0]       loc;
  logic             hi;
  logic [2:0]       leaf;
  logic [1:0]       ub;
  logic [1:0]       ps4;
  logic [3:0]       ps8;
  logic             wr_l4, wr_l2, wr_u;

  // Each half of the schedule (12 ops) repeats: 4 root ops, 2 len-4 f, leaf pair, 2 len-4 g, leaf pair.
  function automatic logic [3:0] loc_of(input logic [4:0] idx);
    loc_of = (idx >= 5'd12) ? 4'(idx - 5'd12) : idx[3:0];
  endfunction

  function automatic logic is_leaf(input logic [4:0] idx);
    logic [3:0] l;
    l = loc_of(idx);
    is_leaf = (l == 4'd6) || (l == 4'd7) || (l == 4'd10) || (l == 4'd11);
  endfunction

  function automatic logic [2:0] leaf_of(input logic [4:0] idx);
    logic [3:0] l;
    l = loc_of(idx);
    leaf_of = {idx >= 5'd12, l >= 4'd10, l[0]};
  endfunction

  assign accept = (state_q == S_IDLE) && start;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign u_hat  = u_q;

  // Partial sums are derived from the decided bits, so a leaf decision is visible to the next g op.
  always_comb begin
    loc  = loc_of(cnt_q);
    hi   = (cnt_q >= 5'd12);
    leaf = leaf_of(cnt_q);
    ub   = hi ? u_q[5:4] : u_q[1:0];
    ps4  = {ub[1], ub[0] ^ ub[1]};
    ps8  = {u_q[3], u_q[2] ^ u_q[3], u_q[1] ^ u_q[3], ^u_q[3:0]};
    fg_a      = '0;
    fg_b      = '0;
    fg_f_flag = 1'b0;
    fg_s      = 1'b0;
    wr_l4     = 1'b0;
    wr_l2     = 1'b0;
    wr_u      = 1'b0;
    if (state_q == S_RUN) begin
      if (loc < 4'd4) begin
        fg_a      = ch_q[{1'b0, loc[1:0]}];
        fg_b      = ch_q[{1'b1, loc[1:0]}];
        fg_f_flag = ~hi;
        fg_s      = hi & ps8[loc[1:0]];
        wr_l4     = 1'b1;
      end else if (is_leaf(cnt_q)) begin
        fg_a      = l2_q[0];
        fg_b      = l2_q[1];
        fg_f_flag = ~loc[0];
        fg_s      = loc[0] & u_q[{leaf[2:1], 1'b0}];
        wr_u      = 1'b1;
      end else begin
        fg_a      = l4_q[{1'b0, loc[0]}];
        fg_b      = l4_q[{1'b1, loc[0]}];
        fg_f_flag = (loc < 4'd8);
        fg_s      = (loc >= 4'd8) & ps4[loc[0]];
        wr_l2     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nxt     = cnt_q + 5'd1;
`ifdef SC_FROZEN_SKIP_EN
    // Leaves come in pairs, so at most two consecutive ops can be skipped; u stays 0 from the start clear.
    for (int k = 0; k < 2; k++) begin
      if ((nxt < N_OPS) && is_leaf(nxt) && frz_q[leaf_of(nxt)]) nxt = nxt + 5'd1;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (nxt >= N_OPS) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = nxt;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      frz_q   <= '0;
      for (int k = 0; k < 8; k++) ch_q[k] <= '0;
      for (int k = 0; k < 4; k++) l4_q[k] <= '0;
      for (int k = 0; k < 2; k++) l2_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        for (int k = 0; k < 8; k++) ch_q[k] <= llr_in[k*LLR_W +: LLR_W];
        frz_q <= frozen;
        u_q   <= '0;
      end
      if (wr_l4) l4_q[loc[1:0]] <= fg_dout;
      if (wr_l2) l2_q[loc[0]] <= fg_dout;
      if (wr_u)  u_q[leaf] <= ~frz_q[leaf] & fg_dout[LLR_W-1];
    end
  end

endmodule

// File: tb/tb_sc_dec8_ctrl.sv
// Scoreboard bench for sc_dec8_ctrl with a behavioural f/g unit; expected u_hat values are hand-derived codewords.
module tb_sc_dec8_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [95:0] llr_in = '0;
  logic [7:0]  frozen = '0;
  logic        busy, done;
  logic [7:0]  u_hat;
  logic [11:0] fg_a, fg_b, fg_dout;
  logic        fg_f_flag, fg_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [7:0] u;
    int         lat;
    int         p;
  } exp_t;
  exp_t sbq[$];

  sc_dec8_ctrl #(.LLR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .llr_in(llr_in), .frozen(frozen),
    .busy(busy), .done(done), .u_hat(u_hat), .fg_a(fg_a), .fg_b(fg_b),
    .fg_f_flag(fg_f_flag), .fg_s(fg_s), .fg_dout(fg_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural f/g unit: f = sign product * min magnitude, g = b + (1-2s)a, saturated to 12 bits.
  logic signed [13:0] sa, sb, ma, mb, r;
  always_comb begin
    sa = $signed(fg_a);
    sb = $signed(fg_b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    if (fg_f_flag) begin
      r = (ma < mb) ? ma : mb;
      if ((sa < 0) ^ (sb < 0)) r = -r;
    end else begin
      r = fg_s ? (sb - sa) : (sb + sa);
    end
    if (r > 14'sd2047) r = 14'sd2047;
    if (r < -14'sd2048) r = -14'sd2048;
    fg_dout = r[11:0];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [7:0] f);
`ifdef SC_FROZEN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    return 24 - (SKIP ? $countones(f) : 0);
  endfunction

  // Channel LLRs for a noiseless codeword: bit 0 -> +mag, bit 1 -> -mag.
  function automatic logic [95:0] mk(input logic [7:0] bits, input int mag);
    logic [95:0] v;
    for (int i = 0; i < 8; i++) v[i*12 +: 12] = bits[i] ? 12'(-mag) : 12'(mag);
    return v;
  endfunction

  // Monitor: every done pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      check("done_width", int'(prev_done), 0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 want=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("u_hat", int'(u_hat), int'(e.u));
        check("latency", cyc - e.p, e.lat);
      end
    end
    prev_done <= done;
  end

  task automatic issue(input logic [95:0] l, input logic [7:0] f, input logic [7:0] eu, input bit push);
    exp_t e;
    @(negedge clk);
    llr_in = l;
    frozen = f;
    start  = 1'b1;
    if (push) begin
      e.u = eu; e.lat = lat_of(f); e.p = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=busy want=idle", name);
    end
  endtask

  task automatic run_vec(input logic [95:0] l, input logic [7:0] f, input logic [7:0] eu);
    int bc;
    issue(l, f, eu, 1'b1);
    bc = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy) bc++;
      else break;
    end
    check("busy_cycles", bc, lat_of(f) + 1);
    check("u_hat_hold", int'(u_hat), int'(eu));
    check("fg_a_idle", int'(fg_a), 0);
    wait_idle("run_vec");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_u_hat", int'(u_hat), 0);
    check("rst_fg_a", int'(fg_a), 0);
    check("rst_fg_b", int'(fg_b), 0);
    check("rst_fg_f", int'(fg_f_flag), 0);
    check("rst_fg_s", int'(fg_s), 0);
    rst_n = 1'b1;

    run_vec(mk(8'h00, 16), 8'h00, 8'h00);
    run_vec(mk(8'hFF, 16), 8'h00, 8'h80);
    run_vec(mk(8'hFF, 16), 8'hFF, 8'h00);
    run_vec(mk(8'hFF, 16), 8'h80, 8'h00);
    run_vec(mk(8'hF0, 16), 8'h17, 8'h88);
    run_vec(mk(8'h33, 16), 8'h00, 8'h20);

    // Start re-pulsed mid-run with different inputs must be ignored.
    issue(mk(8'hFF, 16), 8'h00, 8'h80, 1'b1);
    repeat (4) @(negedge clk);
    llr_in = mk(8'h33, 16);
    frozen = 8'hFF;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("restart");
    check("restart_u_hat", int'(u_hat), 8'h80);

    // Reset mid-run aborts with no done; decoding resumes cleanly afterwards.
    issue(mk(8'h03, 16), 8'h00, 8'h02, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_u_hat", int'(u_hat), 8'h02);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_u_hat", int'(u_hat), 0);
    check("abort_fg_a", int'(fg_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(8'h03, 16), 8'h00, 8'h02);

    // Start held high: a decode is accepted every lat+2 cycles.
    begin
      int p0, lat, n;
      exp_t e;
      @(negedge clk);
      llr_in = mk(8'hFF, 16);
      frozen = 8'h00;
      start  = 1'b1;
      lat = lat_of(8'h00);
      p0  = cyc + 1;
      for (int k = 0; k < 3; k++) begin
        e.u = 8'h80; e.lat = lat; e.p = p0 + k * (lat + 2);
        sbq.push_back(e);
      end
      n = 0;
      while (sbq.size() != 0 && n < 300) begin
        @(negedge clk);
        #1;
        n++;
      end
      start = 1'b0;
      if (n >= 300) begin
        checks++;
        failures++;
        $display("FAIL b2b_timeout got=%0d want=0 pending", sbq.size());
      end
    end
    wait_idle("b2b");
    repeat (30) @(negedge clk);
    check("final_pending", sbq.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_dec8_ctrl.md
SC_DEC8_CTRL -- requirements
Module: sc_dec8_ctrl

Interface
REQ-001 SHALL have parameter LLR_W, default 12, LLR word width; 12 is the only supported value, matching the shared f/g unit.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  decode request.
REQ-005 SHALL have port llr_in  input  8*LLR_W  channel LLRs; element i at bits [12i+11:12i].
REQ-006 SHALL have port frozen  input  8  frozen-bit mask; bit i = 1 means u_i is frozen.
REQ-007 SHALL have port busy  output  1  high while a decode is in progress.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port u_hat  output  8  decoded bits; bit i = u_i.
REQ-010 SHALL have ports fg_a and fg_b  output  LLR_W  operands to the f/g unit.
REQ-011 SHALL have ports fg_f_flag and fg_s  output  1  f/g unit select (1 = f) and g partial-sum bit.
REQ-012 SHALL have port fg_dout  input  LLR_W  combinational f/g result, already saturated by the unit.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the last op; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL capture llr_in and frozen only on the clk edge where start=1 in IDLE; start in RUN or DONE SHALL be ignored.
REQ-015 SHALL issue exactly one f/g op per RUN cycle and register fg_dout into internal LLR storage (4 length-4 words, 2 length-2 words) on the same edge.
REQ-016 SHALL use a fixed depth-first SC schedule on a node of length n (8, 4, 2): n/2 f ops for i ascending (fg_a = LLR[i], fg_b = LLR[i+n/2]); then the left child; then n/2 g ops with fg_s = the left child's partial-sum bit i; then the right child.
REQ-017 SHALL complete a full schedule in 24 ops.
REQ-018 SHALL decide each leaf on the edge that produces it: u_i = frozen[i] ? 0 : fg_dout[11].
REQ-019 SHALL update partial sums (Arikan XOR butterfly) on the same edge as the leaf decision, so a following g op in the next cycle sees the updated value.
REQ-020 SHALL assert busy in RUN and DONE, and deassert it in IDLE.
REQ-021 SHALL pulse done for exactly the DONE cycle, with done rising 24 cycles after the start edge.
REQ-022 SHALL hold u_hat stable from DONE until the next accepted start, and clear it to 0 on that start edge.
REQ-023 SHALL hold fg_a, fg_b, fg_f_flag and fg_s at 0 outside RUN.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state IDLE, op counter 0, busy=0, done=0, u_hat=0, all fg_* outputs 0, and all LLR and partial-sum storage to 0.
REQ-025 SHALL abort a decode when rst_n is asserted during RUN, produce no done pulse for it, and accept a new start on the first edge after rst_n rises.

Configuration
REQ-026 SHALL support macro SC_FROZEN_SKIP_EN; when defined, a length-2 f or g op whose only product is a frozen leaf SHALL be skipped with no cycle consumed, its decision forced to 0 and partial sums updated accordingly.
REQ-027 SHALL, with SC_FROZEN_SKIP_EN defined, produce done 24 - popcount(frozen) cycles after start; without it, always 24 cycles after start, with u_hat identical in both builds.

Verification
REQ-028 SHALL be verified by: all llr_in = 12'h010, frozen = 8'h00 -> u_hat = 8'h00; done 24 cycles after start; busy high 25 cycles.
REQ-029 SHALL be verified by: all llr_in = 12'hFF0, frozen = 8'h00 -> u_hat = 8'h80 (all-ones codeword).
REQ-030 SHALL be verified by: all llr_in = 12'hFF0, frozen = 8'hFF -> u_hat = 8'h00; done at 24 cycles without SC_FROZEN_SKIP_EN and at 16 cycles with it.
REQ-031 SHALL be verified by: start re-pulsed at cycle 5 of RUN with different llr_in -> ignored; result matches the first vector's decode.
REQ-032 SHALL be verified by: rst_n pulsed low at cycle 10 of RUN -> busy, done and u_hat are 0 immediately; a new start after release decodes correctly with no stale done.
REQ-033 SHALL be verified by: back-to-back start held high continuously -> a new decode accepted every 26 cycles (24 RUN + DONE + IDLE); each done pulse is exactly one cycle wide.
